// File: rtl/piano_voice_alloc_if.sv
// Note-event bus feeding the voice allocator: valid/ready handshake
// carrying press/release, note id and octave.
interface piano_voice_alloc_if #(
   parameter int NOTE_W = 4,
   parameter int OCT_W  = 3
) ();
   logic              ev_valid;
   logic              ev_ready;
   logic              ev_press;
   logic [NOTE_W-1:0] ev_note;
   logic [OCT_W-1:0]  ev_octave;

   // Event source (keyboard decode / note mapping side)
   modport master (
      output ev_valid,
      output ev_press,
      output ev_note,
      output ev_octave,
      input  ev_ready
   );

   // Event sink (voice allocator side)
   modport slave (
      input  ev_valid,
      input  ev_press,
      input  ev_note,
      input  ev_octave,
      output ev_ready
   );
endinterface

// File: rtl/piano_voice_alloc.sv
// Polyphonic voice allocator. Each accepted note event is resolved by a
// one-slot-per-cycle scan (match / lowest free / oldest) followed by a
// commit cycle; voice outputs are registered copies of the slot state.
// Optional feature macro: PIANO_SUSTAIN_EN (adds the sustain pedal input,
// per-slot release-held flag and deferred release on pedal up).
module piano_voice_alloc #(
   parameter int NUM_VOICES = 4,
   parameter int NOTE_W     = 4,
   parameter int OCT_W      = 3
) (
   input  logic                             CLK100MHZ,
   input  logic                             CPU_RESETN,
   piano_voice_alloc_if.slave               ev_bus,
`ifdef PIANO_SUSTAIN_EN
   input  logic                             sustain,
`endif
   output logic [NUM_VOICES-1:0]            voice_active,
   output logic [NUM_VOICES*NOTE_W-1:0]     voice_note,
   output logic [NUM_VOICES*OCT_W-1:0]      voice_octave,
   output logic [NUM_VOICES-1:0]            voice_trig,
   output logic                             steal_pulse,
   output logic [$clog2(NUM_VOICES+1)-1:0]  active_count
);

   localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
   localparam int AGE_W = IDX_W;
   localparam int CNT_W = $clog2(NUM_VOICES + 1);
   localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(NUM_VOICES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_VOICES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SCAN,
      S_COMMIT
   } state_t;

   state_t            state_reg;
   logic [IDX_W-1:0]  idx_reg;

   // Event latched on the accepting edge
   logic              lat_press_reg;
   logic [NOTE_W-1:0] lat_note_reg;
   logic [OCT_W-1:0]  lat_oct_reg;

   // Scan results
   logic              hit_found_reg;
   logic [IDX_W-1:0]  hit_idx_reg;
   logic              free_found_reg;
   logic [IDX_W-1:0]  free_idx_reg;
   logic              old_found_reg;
   logic [IDX_W-1:0]  old_idx_reg;
   logic [AGE_W-1:0]  old_age_reg;

   // Per-slot state; held in flops because commit touches every age at once
   logic              slot_active_reg [NUM_VOICES];
   logic [NOTE_W-1:0] slot_note_reg   [NUM_VOICES];
   logic [OCT_W-1:0]  slot_oct_reg    [NUM_VOICES];
   logic [AGE_W-1:0]  slot_age_reg    [NUM_VOICES];

   // Commit-cycle pulses, forwarded to the outputs one cycle later
   logic [NUM_VOICES-1:0] trig_reg;
   logic                  steal_reg;

   logic [NUM_VOICES-1:0] slot_active_vec;
   logic [CNT_W-1:0]      count_next;
   logic [IDX_W-1:0]      commit_idx;
   logic                  note_ok;

   // Note ids 1..12 are real keys; 0 and 13+ are special or ignored
   function automatic logic note_in_range(input logic [NOTE_W-1:0] n);
      return (32'(n) >= 32'd1) && (32'(n) <= 32'd12);
   endfunction

`ifdef PIANO_SUSTAIN_EN
   logic sus_reg;
   logic sus_pend_reg;
   logic slot_held_reg [NUM_VOICES];
   logic sus_service;

   // Pending pedal-up release is serviced in an IDLE cycle, blocking intake
   assign sus_service     = (state_reg == S_IDLE) && sus_pend_reg;
   assign ev_bus.ev_ready = (state_reg == S_IDLE) && !sus_pend_reg;

   // Pedal delay register and falling-edge pending flag
   always_ff @(posedge CLK100MHZ) begin
      if (!CPU_RESETN) begin
         sus_reg      <= 1'b0;
         sus_pend_reg <= 1'b0;
      end else begin
         sus_reg      <= sustain;
         sus_pend_reg <= (sus_pend_reg && !sus_service) || (sus_reg && !sustain);
      end
   end
`else
   assign ev_bus.ev_ready = (state_reg == S_IDLE);
`endif

   // Flatten slot activity for the popcount
   for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_active_vec
      assign slot_active_vec[gi] = slot_active_reg[gi];
   end

   // Population count of the slot activity flags
   always_comb begin
      count_next = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         count_next = count_next + CNT_W'(slot_active_vec[i]);
      end
   end

   // Target slot for a press: retrigger match, else lowest free, else oldest
   always_comb begin
      note_ok = note_in_range(lat_note_reg);
      if (hit_found_reg) begin
         commit_idx = hit_idx_reg;
      end else if (free_found_reg) begin
         commit_idx = free_idx_reg;
      end else begin
         commit_idx = old_idx_reg;
      end
   end

   // Allocation FSM: accept event, scan slots, commit the action
   always_ff @(posedge CLK100MHZ) begin
      if (!CPU_RESETN) begin
         state_reg      <= S_IDLE;
         idx_reg        <= '0;
         lat_press_reg  <= 1'b0;
         lat_note_reg   <= '0;
         lat_oct_reg    <= '0;
         hit_found_reg  <= 1'b0;
         hit_idx_reg    <= '0;
         free_found_reg <= 1'b0;
         free_idx_reg   <= '0;
         old_found_reg  <= 1'b0;
         old_idx_reg    <= '0;
         old_age_reg    <= '0;
         trig_reg       <= '0;
         steal_reg      <= 1'b0;
         for (int i = 0; i < NUM_VOICES; i++) begin
            slot_active_reg[i] <= 1'b0;
            slot_note_reg[i]   <= '0;
            slot_oct_reg[i]    <= '0;
            slot_age_reg[i]    <= '0;
`ifdef PIANO_SUSTAIN_EN
            slot_held_reg[i]   <= 1'b0;
`endif
         end
      end else begin
         trig_reg  <= '0;
         steal_reg <= 1'b0;
         case (state_reg)
            S_IDLE: begin
`ifdef PIANO_SUSTAIN_EN
               if (sus_service) begin
                  for (int i = 0; i < NUM_VOICES; i++) begin
                     if (slot_held_reg[i]) begin
                        slot_active_reg[i] <= 1'b0;
                        slot_held_reg[i]   <= 1'b0;
                     end
                  end
               end
`endif
               if (ev_bus.ev_valid && ev_bus.ev_ready) begin
                  lat_press_reg  <= ev_bus.ev_press;
                  lat_note_reg   <= ev_bus.ev_note;
                  lat_oct_reg    <= ev_bus.ev_octave;
                  hit_found_reg  <= 1'b0;
                  free_found_reg <= 1'b0;
                  old_found_reg  <= 1'b0;
                  hit_idx_reg    <= '0;
                  free_idx_reg   <= '0;
                  old_idx_reg    <= '0;
                  old_age_reg    <= '0;
                  idx_reg        <= '0;
                  state_reg      <= S_SCAN;
               end
            end

            S_SCAN: begin
               if (slot_active_reg[idx_reg]) begin
                  if (!hit_found_reg &&
                      slot_note_reg[idx_reg] == lat_note_reg &&
                      slot_oct_reg[idx_reg] == lat_oct_reg) begin
                     hit_found_reg <= 1'b1;
                     hit_idx_reg   <= idx_reg;
                  end
                  // strict compare keeps the lowest index on equal ages
                  if (!old_found_reg || slot_age_reg[idx_reg] > old_age_reg) begin
                     old_found_reg <= 1'b1;
                     old_idx_reg   <= idx_reg;
                     old_age_reg   <= slot_age_reg[idx_reg];
                  end
               end else if (!free_found_reg) begin
                  free_found_reg <= 1'b1;
                  free_idx_reg   <= idx_reg;
               end
               if (idx_reg == IDX_LAST) begin
                  state_reg <= S_COMMIT;
               end else begin
                  idx_reg <= idx_reg + IDX_W'(1);
               end
            end

            S_COMMIT: begin
               state_reg <= S_IDLE;
               if (lat_press_reg) begin
                  if (note_ok) begin
                     steal_reg <= !hit_found_reg && !free_found_reg;
                     for (int i = 0; i < NUM_VOICES; i++) begin
                        if (IDX_W'(i) == commit_idx) begin
                           slot_active_reg[i] <= 1'b1;
                           slot_note_reg[i]   <= lat_note_reg;
                           slot_oct_reg[i]    <= lat_oct_reg;
                           slot_age_reg[i]    <= '0;
                           trig_reg[i]        <= 1'b1;
`ifdef PIANO_SUSTAIN_EN
                           slot_held_reg[i]   <= 1'b0;
`endif
                        end else if (slot_active_reg[i] && slot_age_reg[i] != AGE_MAX) begin
                           slot_age_reg[i] <= slot_age_reg[i] + AGE_W'(1);
                        end
                     end
                  end
               end else if (lat_note_reg == '0) begin
                  // all-notes-off ignores the pedal
                  for (int i = 0; i < NUM_VOICES; i++) begin
                     slot_active_reg[i] <= 1'b0;
`ifdef PIANO_SUSTAIN_EN
                     slot_held_reg[i]   <= 1'b0;
`endif
                  end
               end else if (note_ok && hit_found_reg) begin
`ifdef PIANO_SUSTAIN_EN
                  if (sus_reg) begin
                     slot_held_reg[hit_idx_reg] <= 1'b1;
                  end else begin
                     slot_active_reg[hit_idx_reg] <= 1'b0;
                     slot_held_reg[hit_idx_reg]   <= 1'b0;
                  end
`else
                  slot_active_reg[hit_idx_reg] <= 1'b0;
`endif
               end
            end

            default: state_reg <= S_IDLE;
         endcase
      end
   end

   // Output registers mirror slot state one cycle after commit
   always_ff @(posedge CLK100MHZ) begin
      if (!CPU_RESETN) begin
         voice_active <= '0;
         voice_note   <= '0;
         voice_octave <= '0;
         voice_trig   <= '0;
         steal_pulse  <= 1'b0;
         active_count <= '0;
      end else begin
         for (int i = 0; i < NUM_VOICES; i++) begin
            voice_active[i]                 <= slot_active_reg[i];
            voice_note[i*NOTE_W +: NOTE_W]  <= slot_note_reg[i];
            voice_octave[i*OCT_W +: OCT_W]  <= slot_oct_reg[i];
         end
         voice_trig   <= trig_reg;
         steal_pulse  <= steal_reg;
         active_count <= count_next;
      end
   end

endmodule
